// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one pipelined ALU between two requesters (r0, r1). Operations are
// granted round-robin and forwarded combinationally to the ALU. The requester
// ID of every accepted operation is pushed into a small in-flight tag FIFO.
// Results coming back from the ALU are steered to the requester at the FIFO
// head, so results always return in issue order whatever the ALU latency is.
//
// All push/stop pairs use the same handshake: a transfer happens in a cycle
// where push=1 and stop=0.
//
// Parameters
//   TAGDEPTH     in-flight tag FIFO depth, power of 2 in 2..16
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset (0 = reset)
//   rN_pushin    requester N offers an operation
//   rN_stopout   requester N's offer cannot be accepted this cycle
//   rN_ctl/a/b/ci  requester N operation fields (2/8/8/1 bits)
//   rN_pushout   valid result for requester N
//   rN_stopin    requester N refuses the result
//   rN_z/cout    result data to requester N (8/1 bits)
//   alu_pushin   operation valid towards the ALU
//   alu_ctl/a/b/ci granted operation fields
//   alu_stopout  ALU refuses the operation
//   alu_pushout  ALU result valid
//   alu_z/cout   ALU result data
//   alu_stopin   refusal of the ALU result (mirrors the head requester)
//   gcnt0/gcnt1  accepted issues per requester, saturating at 16'hFFFF
//   err          sticky protocol error: ALU result with nothing outstanding
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int TAGDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,

  // requester 0
  input  logic        r0_pushin,
  output logic        r0_stopout,
  input  logic [1:0]  r0_ctl,
  input  logic [7:0]  r0_a,
  input  logic [7:0]  r0_b,
  input  logic        r0_ci,
  output logic        r0_pushout,
  input  logic        r0_stopin,
  output logic [7:0]  r0_z,
  output logic        r0_cout,

  // requester 1
  input  logic        r1_pushin,
  output logic        r1_stopout,
  input  logic [1:0]  r1_ctl,
  input  logic [7:0]  r1_a,
  input  logic [7:0]  r1_b,
  input  logic        r1_ci,
  output logic        r1_pushout,
  input  logic        r1_stopin,
  output logic [7:0]  r1_z,
  output logic        r1_cout,

  // ALU issue side
  output logic        alu_pushin,
  output logic [1:0]  alu_ctl,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_ci,
  input  logic        alu_stopout,

  // ALU return side
  input  logic        alu_pushout,
  input  logic [7:0]  alu_z,
  input  logic        alu_cout,
  output logic        alu_stopin,

  // status
  output logic [15:0] gcnt0,
  output logic [15:0] gcnt1,
  output logic        err
);

  localparam int PW = (TAGDEPTH > 1) ? $clog2(TAGDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(TAGDEPTH);

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  req_id_e       last_grant;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  req_id_e       tag_mem [TAGDEPTH];

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic    grant_valid;
  req_id_e grant_id;
  logic    tag_full;
  logic    tag_empty;
  logic    issue;
  req_id_e head_id;
  logic    pop;
  logic    orphan;

  // Round-robin: a lone requester always wins; on contention the requester
  // that was not granted last time wins.
  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = r0_pushin | r1_pushin;
    grant_id    = REQ0;
    if (r0_pushin && r1_pushin) begin
      grant_id = (last_grant == REQ1) ? REQ0 : REQ1;
    end else if (r1_pushin) begin
      grant_id = REQ1;
    end
  end

  assign tag_full  = (count == FULL_COUNT);
  assign tag_empty = (count == '0);

  // A full FIFO blocks issue even if a result pops in the same cycle; the
  // freed slot becomes usable from the next cycle on.
  assign alu_pushin = grant_valid & ~tag_full;
  assign issue      = alu_pushin & ~alu_stopout;

  assign r0_stopout = ~(grant_valid && grant_id == REQ0) | tag_full | alu_stopout;
  assign r1_stopout = ~(grant_valid && grant_id == REQ1) | tag_full | alu_stopout;

  // Operand mux: granted requester's fields, zero when nobody requests.
  always_comb begin
    alu_ctl = 2'b00;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_ci  = 1'b0;
    if (grant_valid) begin
      if (grant_id == REQ0) begin
        alu_ctl = r0_ctl;
        alu_a   = r0_a;
        alu_b   = r0_b;
        alu_ci  = r0_ci;
      end else begin
        alu_ctl = r1_ctl;
        alu_a   = r1_a;
        alu_b   = r1_b;
        alu_ci  = r1_ci;
      end
    end
  end

  assign head_id = tag_mem[rd_ptr];

  // Return routing: the result goes only to the requester at the FIFO head,
  // and that requester's stop is the only one reflected back to the ALU.
  // With nothing outstanding the result is accepted and dropped.
  always_comb begin
    r0_pushout = 1'b0;
    r0_z       = 8'h00;
    r0_cout    = 1'b0;
    r1_pushout = 1'b0;
    r1_z       = 8'h00;
    r1_cout    = 1'b0;
    alu_stopin = 1'b0;
    if (!tag_empty) begin
      if (head_id == REQ0) begin
        r0_pushout = alu_pushout;
        r0_z       = alu_z;
        r0_cout    = alu_cout;
        alu_stopin = r0_stopin;
      end else begin
        r1_pushout = alu_pushout;
        r1_z       = alu_z;
        r1_cout    = alu_cout;
        alu_stopin = r1_stopin;
      end
    end
  end

  assign pop    = ~tag_empty & alu_pushout & ~alu_stopin;
  assign orphan =  tag_empty & alu_pushout;

  // ---------------------------------------------------------------------------
  // Control state: pointers, occupancy, arbitration history, counters, error
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= REQ1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      gcnt0      <= 16'h0000;
      gcnt1      <= 16'h0000;
      err        <= 1'b0;
    end else begin
      if (issue) begin
        last_grant <= grant_id;
        wr_ptr     <= wr_ptr + PW'(1);
        if (grant_id == REQ0) begin
          if (gcnt0 != 16'hFFFF) gcnt0 <= gcnt0 + 16'd1;
        end else begin
          if (gcnt1 != 16'hFFFF) gcnt1 <= gcnt1 + 16'd1;
        end
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      // Issue and pop in the same cycle cancel out.
      case ({issue, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (orphan) begin
        err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag storage
  // ---------------------------------------------------------------------------
  // NOTE: the tag array has no reset; entries are only read when count marks
  // them valid, and clearing the pointers/count is enough to discard them.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[wr_ptr] <= grant_id;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter (TAGDEPTH=4). Inputs are driven 1 ns after the
// rising edge, outputs are sampled 2 ns or more after it. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic        clk;
  logic        rst;

  logic        r0_pushin, r0_stopout, r0_ci, r0_pushout, r0_stopin, r0_cout;
  logic [1:0]  r0_ctl;
  logic [7:0]  r0_a, r0_b, r0_z;
  logic        r1_pushin, r1_stopout, r1_ci, r1_pushout, r1_stopin, r1_cout;
  logic [1:0]  r1_ctl;
  logic [7:0]  r1_a, r1_b, r1_z;

  logic        alu_pushin, alu_ci, alu_stopout, alu_pushout, alu_cout, alu_stopin;
  logic [1:0]  alu_ctl;
  logic [7:0]  alu_a, alu_b, alu_z;
  logic [15:0] gcnt0, gcnt1;
  logic        err;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.TAGDEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .r0_pushin   (r0_pushin),
    .r0_stopout  (r0_stopout),
    .r0_ctl      (r0_ctl),
    .r0_a        (r0_a),
    .r0_b        (r0_b),
    .r0_ci       (r0_ci),
    .r0_pushout  (r0_pushout),
    .r0_stopin   (r0_stopin),
    .r0_z        (r0_z),
    .r0_cout     (r0_cout),
    .r1_pushin   (r1_pushin),
    .r1_stopout  (r1_stopout),
    .r1_ctl      (r1_ctl),
    .r1_a        (r1_a),
    .r1_b        (r1_b),
    .r1_ci       (r1_ci),
    .r1_pushout  (r1_pushout),
    .r1_stopin   (r1_stopin),
    .r1_z        (r1_z),
    .r1_cout     (r1_cout),
    .alu_pushin  (alu_pushin),
    .alu_ctl     (alu_ctl),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ci      (alu_ci),
    .alu_stopout (alu_stopout),
    .alu_pushout (alu_pushout),
    .alu_z       (alu_z),
    .alu_cout    (alu_cout),
    .alu_stopin  (alu_stopin),
    .gcnt0       (gcnt0),
    .gcnt1       (gcnt1),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_r0(input logic p, input logic [1:0] c, input logic [7:0] a,
                        input logic [7:0] b, input logic ci);
    r0_pushin = p; r0_ctl = c; r0_a = a; r0_b = b; r0_ci = ci;
  endtask

  task automatic set_r1(input logic p, input logic [1:0] c, input logic [7:0] a,
                        input logic [7:0] b, input logic ci);
    r1_pushin = p; r1_ctl = c; r1_a = a; r1_b = b; r1_ci = ci;
  endtask

  task automatic alu_result(input logic p, input logic [7:0] z, input logic co);
    alu_pushout = p; alu_z = z; alu_cout = co;
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    set_r0(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    set_r1(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    r0_stopin   = 1'b0;
    r1_stopin   = 1'b0;
    alu_stopout = 1'b0;
    alu_result(1'b0, 8'h00, 1'b0);

    // ---------------- reset state ----------------
    #12;
    check("rst_gcnt0",     gcnt0, 0);
    check("rst_gcnt1",     gcnt1, 0);
    check("rst_err",       err, 0);
    check("rst_r0_stop",   r0_stopout, 1);
    check("rst_r1_stop",   r1_stopout, 1);
    check("rst_alu_push",  alu_pushin, 0);
    check("rst_alu_stopi", alu_stopin, 0);
    check("rst_r0_push",   r0_pushout, 0);
    check("rst_r1_push",   r1_pushout, 0);
    check("rst_alu_a",     alu_a, 0);
    rst = 1'b1;
    tick();

    // ---------------- round robin, fill FIFO ----------------
    set_r0(1'b1, 2'd1, 8'h10, 8'h01, 1'b0);
    set_r1(1'b1, 2'd2, 8'h20, 8'h02, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i % 2 == 0) begin
        check("rr_alu_a_r0", alu_a, 8'h10);
        check("rr_alu_ctl_r0", alu_ctl, 2'd1);
        check("rr_r0_stop", r0_stopout, 0);
        check("rr_r1_stop", r1_stopout, 1);
      end else begin
        check("rr_alu_a_r1", alu_a, 8'h20);
        check("rr_alu_ci_r1", alu_ci, 1);
        check("rr_r0_stop", r0_stopout, 1);
        check("rr_r1_stop", r1_stopout, 0);
      end
      check("rr_alu_push", alu_pushin, 1);
      tick();
    end
    #1;
    check("full_alu_push", alu_pushin, 0);
    check("full_r0_stop",  r0_stopout, 1);
    check("full_r1_stop",  r1_stopout, 1);
    check("rr_gcnt0",      gcnt0, 2);
    check("rr_gcnt1",      gcnt1, 2);

    // one result while full: still blocked this cycle
    alu_result(1'b1, 8'hA1, 1'b1);
    #1;
    check("full_pop_r0_push", r0_pushout, 1);
    check("full_pop_r0_z",    r0_z, 8'hA1);
    check("full_pop_r0_cout", r0_cout, 1);
    check("full_pop_r1_push", r1_pushout, 0);
    check("full_same_cycle",  alu_pushin, 0);
    tick();
    alu_result(1'b0, 8'h00, 1'b0);
    #1;
    check("after_pop_issue",  alu_pushin, 1);
    check("after_pop_r0_win", r0_stopout, 0);
    set_r0(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    set_r1(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    tick();

    // drain remaining tags in issue order: r1, r0, r1
    alu_result(1'b1, 8'hB2, 1'b0);
    #1;
    check("drain1_r1_push", r1_pushout, 1);
    check("drain1_r0_push", r0_pushout, 0);
    check("drain1_r1_z",    r1_z, 8'hB2);
    tick();
    alu_result(1'b1, 8'hC3, 1'b0);
    #1;
    check("drain2_r0_push", r0_pushout, 1);
    check("drain2_r1_push", r1_pushout, 0);
    check("drain2_r0_z",    r0_z, 8'hC3);
    tick();
    alu_result(1'b1, 8'hD4, 1'b1);
    #1;
    check("drain3_r1_push", r1_pushout, 1);
    check("drain3_r1_cout", r1_cout, 1);
    tick();
    alu_result(1'b0, 8'h00, 1'b0);
    #1;
    check("drain_err", err, 0);

    // ---------------- single requester, add ----------------
    tick();
    set_r0(1'b1, 2'd0, 8'h05, 8'h03, 1'b0);
    #1;
    check("single_alu_a",   alu_a, 8'h05);
    check("single_alu_b",   alu_b, 8'h03);
    check("single_alu_ctl", alu_ctl, 2'd0);
    check("single_r0_stop", r0_stopout, 0);
    tick();
    set_r0(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    #1;
    check("single_gcnt0", gcnt0, 3);
    alu_result(1'b1, 8'h08, 1'b0);
    #1;
    check("single_r0_push", r0_pushout, 1);
    check("single_r0_z",    r0_z, 8'h08);
    check("single_r1_push", r1_pushout, 0);
    tick();
    alu_result(1'b0, 8'h00, 1'b0);

    // ---------------- ALU stall ----------------
    set_r1(1'b1, 2'd3, 8'h44, 8'h00, 1'b0);
    alu_stopout = 1'b1;
    #1;
    check("stall_r1_stop",  r1_stopout, 1);
    check("stall_alu_push", alu_pushin, 1);
    check("stall_alu_a",    alu_a, 8'h44);
    tick();
    check("stall_gcnt1", gcnt1, 2);
    alu_stopout = 1'b0;
    #1;
    check("unstall_r1_stop", r1_stopout, 0);
    tick();                                   // issue r1
    set_r1(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    set_r0(1'b1, 2'd0, 8'h55, 8'h00, 1'b0);
    tick();                                   // issue r0
    set_r0(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);

    // ---------------- in-order return with back-pressure ----------------
    alu_result(1'b1, 8'h11, 1'b0);
    r1_stopin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_alu_stopin", alu_stopin, 1);
      check("bp_r1_push",    r1_pushout, 1);
      check("bp_r0_push",    r0_pushout, 0);
      tick();
    end
    r1_stopin = 1'b0;
    #1;
    check("bp_release_stopin", alu_stopin, 0);
    check("bp_release_r1_z",   r1_z, 8'h11);
    tick();
    alu_result(1'b1, 8'h22, 1'b1);
    #1;
    check("bp_r0_after_push", r0_pushout, 1);
    check("bp_r0_after_z",    r0_z, 8'h22);
    check("bp_r0_after_cout", r0_cout, 1);
    check("bp_r1_after_push", r1_pushout, 0);
    tick();
    alu_result(1'b0, 8'h00, 1'b0);
    #1;
    check("bp_gcnt0", gcnt0, 4);
    check("bp_gcnt1", gcnt1, 3);
    check("bp_err",   err, 0);

    // ---------------- orphan result ----------------
    r0_stopin = 1'b1;
    r1_stopin = 1'b1;
    alu_result(1'b1, 8'h99, 1'b1);
    #1;
    check("orph_alu_stopin", alu_stopin, 0);
    check("orph_r0_push",    r0_pushout, 0);
    check("orph_r1_push",    r1_pushout, 0);
    tick();
    alu_result(1'b0, 8'h00, 1'b0);
    r0_stopin = 1'b0;
    r1_stopin = 1'b0;
    #1;
    check("orph_err_set", err, 1);
    tick();
    tick();
    check("orph_err_held", err, 1);

    // ---------------- async reset with tags outstanding ----------------
    set_r0(1'b1, 2'd0, 8'h01, 8'h01, 1'b0);
    tick();                                   // issue r0
    set_r0(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    set_r1(1'b1, 2'd0, 8'h02, 8'h02, 1'b0);
    tick();                                   // issue r1
    set_r1(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
    #1;
    check("pre_rst_gcnt0", gcnt0, 5);
    check("pre_rst_gcnt1", gcnt1, 4);
    #1;
    rst = 1'b0;                               // away from any clock edge
    #1;
    check("async_gcnt0", gcnt0, 0);
    check("async_gcnt1", gcnt1, 0);
    check("async_err",   err, 0);
    tick();
    rst = 1'b1;
    alu_result(1'b1, 8'h77, 1'b0);
    r0_stopin = 1'b1;
    #1;
    check("post_rst_stopin", alu_stopin, 0);
    check("post_rst_r0_push", r0_pushout, 0);
    check("post_rst_r1_push", r1_pushout, 0);
    tick();
    alu_result(1'b0, 8'h00, 1'b0);
    r0_stopin = 1'b0;
    #1;
    check("post_rst_err", err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TAGDEPTH, default 4, SHALL set the in-flight tag FIFO depth (power of 2, 2..16).
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-004 rN_pushin  input  1  requester N (N=0,1) SHALL assert it to offer an operation.
REQ-005 rN_stopout  output  1  SHALL be high when requester N's offer cannot be accepted this cycle.
REQ-006 rN_ctl/rN_a/rN_b/rN_ci  input  2/8/8/1  requester N operation fields.
REQ-007 rN_pushout  output  1  SHALL mark a valid result for requester N.
REQ-008 rN_stopin  input  1  requester N SHALL drive it high to refuse a result.
REQ-009 rN_z/rN_cout  output  8/1  result to requester N.
REQ-010 alu_pushin, alu_ctl, alu_a, alu_b, alu_ci  output  1/2/8/8/1  SHALL carry the granted operation to the ALU.
REQ-011 alu_stopout  input  1  ALU refusal of an operation.
REQ-012 alu_pushout, alu_z, alu_cout  input  1/8/1  ALU result.
REQ-013 alu_stopin  output  1  SHALL refuse an ALU result.
REQ-014 gcnt0/gcnt1  output  16  SHALL count accepted issues per requester, saturating at 16'hFFFF.
REQ-015 err  output  1  SHALL be the sticky protocol-error flag.

Function
REQ-016 A transfer on any push/stop pair SHALL occur exactly when push=1 and stop=0 in the same cycle; senders SHALL hold push and data stable until transfer.
REQ-017 Issue side SHALL be combinational: alu_pushin = (r0_pushin|r1_pushin) & ~tagfull; alu_ctl/a/b/ci SHALL equal the granted requester's fields (zero when none).
REQ-018 Arbitration SHALL be round-robin: single requester wins; on contention the requester not last granted wins; last-granted pointer (reset value 1, so r0 wins first contention) SHALL update only on an accepted issue.
REQ-019 rN_stopout SHALL be 1 when N is not granted, when tag FIFO is full, or when alu_stopout=1; else 0.
REQ-020 Each accepted issue SHALL push the granted requester ID into the tag FIFO and increment that requester's gcnt (saturating).
REQ-021 Tag FIFO full (count==TAGDEPTH) SHALL block issue even if a result pops the same cycle; simultaneous push and pop when not full SHALL leave count unchanged.
REQ-022 Return side SHALL be combinational: when FIFO non-empty, alu_pushout is routed to rH_pushout (H = head ID), rH_z/cout = alu_z/cout, alu_stopin = rH_stopin; the other requester's pushout SHALL be 0.
REQ-023 A result transfer SHALL pop the FIFO head; results SHALL be returned in issue order regardless of ALU latency.
REQ-024 alu_pushout=1 with FIFO empty SHALL set err, drop the result (alu_stopin=0, no rN_pushout).
REQ-025 Tag read/write pointers SHALL wrap modulo TAGDEPTH; count SHALL range 0..TAGDEPTH.
REQ-026 err SHALL remain 1 until reset.

Reset
REQ-027 rst=0 SHALL asynchronously clear FIFO pointers/count, gcnt0/gcnt1, err, and set the pointer to 1; all outputs SHALL then be 0 except rN_stopout=1 for non-granted requesters per REQ-019.
REQ-028 Reset mid-operation SHALL discard all in-flight tags; results arriving after reset release with FIFO empty SHALL follow REQ-024.
REQ-029 Release of rst SHALL take effect at the first rising clk edge with rst=1; no state change SHALL occur on the release itself.

Verification
REQ-030 r0 alone pushes ctl=0,a=8'h05,b=8'h03, ALU stop=0 -> alu_a=8'h05 same cycle, gcnt0=1, result z=8'h08 returned on r0_pushout only.
REQ-031 r0 and r1 push continuously, ALU never stalls -> grants alternate r0,r1,r0,r1; gcnt0=gcnt1 after even count of issues.
REQ-032 Issue 4 ops with no results (TAGDEPTH=4) -> r0_stopout=r1_stopout=1; one result accepted -> next issue allowed the following cycle, not same cycle.
REQ-033 Issues r1 then r0, ALU returns two results, r1_stopin=1 for 3 cycles -> alu_stopin=1 for 3 cycles, r0 receives nothing until r1 result accepted.
REQ-034 alu_pushout=1 with no outstanding ops -> err=1, no rN_pushout, err held until rst=0.
REQ-035 Assert rst=0 mid-cycle with 2 tags outstanding -> count, gcnt, err clear immediately without clk edge.
